// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the MIPS fetch port and data port (data has priority).
// Optional misalignment trap enabled by defining MEM_ARB_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter logic [1:0] INST_SIZE = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  output logic        addr_err,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic [31:0] bus_rdata,
  input  logic        bus_data_ok,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a requester holds req and its fields stable until its one-cycle ok
  // pulse; the address phase completes on bus_req & bus_addr_ok, the data phase on
  // bus_data_ok (which may coincide with bus_addr_ok).
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  r_state;
  logic        r_gnt_data;
  logic        r_bus_req;
  logic        r_bus_wr;
  logic [1:0]  r_bus_size;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_inst_ok;
  logic        r_data_ok;

  logic w_grant_data;
  logic w_grant_inst;
  logic w_misalign;
  logic w_issue_data;
  logic w_capture;
  logic w_trap;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic r_addr_err;

  assign w_misalign = ((data_size == 2'b10) && (data_addr[1:0] != 2'b00)) ||
                      ((data_size == 2'b01) && data_addr[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_trap;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign w_misalign = 1'b0;
  assign addr_err   = 1'b0;
`endif

  assign w_grant_data = (r_state == S_IDLE) && data_req;
  assign w_grant_inst = (r_state == S_IDLE) && !data_req && inst_req;
  assign w_issue_data = w_grant_data && !w_misalign;
  assign w_trap       = w_grant_data && w_misalign;
  assign w_capture    = ((r_state == S_ADDR) && bus_addr_ok && bus_data_ok) ||
                        ((r_state == S_DATA) && bus_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt_data <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_gnt_data <= 1'b1;
            r_state    <= w_misalign ? S_RESP : S_ADDR;
          end else if (w_grant_inst) begin
            r_gnt_data <= 1'b0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_addr_ok) begin
            r_state <= bus_data_ok ? S_RESP : S_DATA;
          end
        end
        S_DATA: begin
          if (bus_data_ok) begin
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus fields are latched once at grant and stay put until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= 2'b00;
      r_bus_wstrb <= 4'b0000;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
    end else if (w_issue_data) begin
      r_bus_req   <= 1'b1;
      r_bus_wr    <= data_wr;
      r_bus_size  <= data_size;
      r_bus_wstrb <= data_wr ? data_sel : 4'b0000;
      r_bus_addr  <= data_addr;
      r_bus_wdata <= data_wdata;
    end else if (w_grant_inst) begin
      r_bus_req   <= 1'b1;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= INST_SIZE;
      r_bus_wstrb <= 4'b0000;
      r_bus_addr  <= inst_addr;
      r_bus_wdata <= 32'h0;
    end else if ((r_state == S_ADDR) && bus_addr_ok) begin
      r_bus_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
    end else begin
      r_inst_ok <= w_capture && !r_gnt_data;
      r_data_ok <= (w_capture && r_gnt_data) || w_trap;
      if (w_capture) begin
        if (r_gnt_data) begin
          r_data_rdata <= bus_rdata;
        end else begin
          r_inst_rdata <= bus_rdata;
        end
      end else if (w_trap) begin
        r_data_rdata <= 32'h0;
      end
    end
  end

  assign stall = (inst_req && !r_inst_ok) || (data_req && !r_data_ok);

  assign inst_rdata  = r_inst_rdata;
  assign inst_ok     = r_inst_ok;
  assign data_rdata  = r_data_rdata;
  assign data_ok     = r_data_ok;
  assign bus_req     = r_bus_req;
  assign bus_wr      = r_bus_wr;
  assign bus_size    = r_bus_size;
  assign bus_wstrb   = r_bus_wstrb;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, multi-cycle corner sequences and
// randomized two-port traffic against a transaction-level model with a scripted slave.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        addr_err;
  logic        stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic [31:0] bus_rdata;
  logic        bus_data_ok;
  logic [1:0]  o_dbg_state;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
    .addr_err(addr_err), .stall(stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_rdata(bus_rdata), .bus_data_ok(bus_data_ok), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          a_wait;
    int          d_wait;
    logic [31:0] rdata;
    logic        exp_wr;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_size;
    int          exp_lat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_inst_rd = 32'h0;
  logic [31:0] m_data_rd = 32'h0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    if (v.is_data) begin
      data_req   = 1'b1;
      data_wr    = v.wr;
      data_size  = v.size;
      data_sel   = v.sel;
      data_addr  = v.addr;
      data_wdata = v.wdata;
    end else begin
      inst_req  = 1'b1;
      inst_addr = v.addr;
    end
  endtask

  // Cycle 0 is the IDLE cycle in which the request is sampled; ok is due in cycle exp_lat-1.
  task automatic run_xfer(input string name, input vec_t v);
    logic        eok;
    logic        ebr;
    logic [31:0] qv;
    for (int c = 1; c < v.exp_lat; c++) begin
      @(negedge clk);
      eok = (c == v.exp_lat - 1);
      ebr = (c <= 1 + v.a_wait);
      chk({name, " bus_req"}, 32'(bus_req), 32'(ebr));
      if (ebr) begin
        chk({name, " bus_addr"}, bus_addr, v.addr);
        chk({name, " bus_wr"}, 32'(bus_wr), 32'(v.exp_wr));
        chk({name, " bus_size"}, 32'(bus_size), 32'(v.exp_size));
        chk({name, " bus_wstrb"}, 32'(bus_wstrb), 32'(v.exp_strb));
        if (v.exp_wr) chk({name, " bus_wdata"}, bus_wdata, v.wdata);
      end
      chk({name, " inst_ok"}, 32'(inst_ok), 32'(eok && !v.is_data));
      chk({name, " data_ok"}, 32'(data_ok), 32'(eok && v.is_data));
      chk({name, " addr_err"}, 32'(addr_err), 32'h0);
      chk({name, " stall"}, 32'(stall),
          32'((inst_req && !(eok && !v.is_data)) || (data_req && !(eok && v.is_data))));
      if (eok && exp_q.size() > 0) begin
        qv = exp_q.pop_front();
        if (v.is_data) m_data_rd = qv;
        else m_inst_rd = qv;
      end
      chk({name, " inst_rdata"}, inst_rdata, m_inst_rd);
      chk({name, " data_rdata"}, data_rdata, m_data_rd);
      bus_addr_ok = (c == 1 + v.a_wait);
      bus_data_ok = (c == 1 + v.a_wait + v.d_wait);
      if (bus_data_ok) begin
        bus_rdata = v.rdata;
        exp_q.push_back(v.rdata);
      end else begin
        bus_rdata = $urandom;
      end
      if (eok) begin
        if (v.is_data) data_req = 1'b0;
        else inst_req = 1'b0;
      end
    end
  endtask

  task automatic gap(input string name);
    @(negedge clk);
    chk({name, " bus_req"}, 32'(bus_req), 32'h0);
    chk({name, " inst_ok"}, 32'(inst_ok), 32'h0);
    chk({name, " data_ok"}, 32'(data_ok), 32'h0);
    chk({name, " addr_err"}, 32'(addr_err), 32'h0);
    chk({name, " state"}, 32'(o_dbg_state), 32'h0);
    chk({name, " stall"}, 32'(stall), 32'(inst_req || data_req));
  endtask

`ifdef MEM_ARB_ALIGN_CHECK_EN
  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
    return ((sz == 2'b10) && (a[1:0] != 2'b00)) || ((sz == 2'b01) && a[0]);
  endfunction

  task automatic run_misalign(input string name);
    @(negedge clk);
    m_data_rd = 32'h0;
    chk({name, " bus_req"}, 32'(bus_req), 32'h0);
    chk({name, " data_ok"}, 32'(data_ok), 32'h1);
    chk({name, " addr_err"}, 32'(addr_err), 32'h1);
    chk({name, " inst_ok"}, 32'(inst_ok), 32'h0);
    chk({name, " data_rdata"}, data_rdata, m_data_rd);
    chk({name, " inst_rdata"}, inst_rdata, m_inst_rd);
    chk({name, " stall"}, 32'(stall), 32'(inst_req));
    data_req = 1'b0;
  endtask
`endif

  function automatic vec_t mk_inst();
    vec_t v;
    v.is_data  = 1'b0;
    v.wr       = 1'b0;
    v.size     = 2'b00;
    v.sel      = 4'b0000;
    v.addr     = {$urandom, 2'b00} >> 2 << 2;
    v.wdata    = 32'h0;
    v.a_wait   = int'($urandom_range(3, 0));
    v.d_wait   = int'($urandom_range(3, 0));
    v.rdata    = $urandom;
    v.exp_wr   = 1'b0;
    v.exp_strb = 4'b0000;
    v.exp_size = 2'b10;
    v.exp_lat  = 3 + v.a_wait + v.d_wait;
    return v;
  endfunction

  function automatic vec_t mk_data();
    vec_t v;
    v.is_data  = 1'b1;
    v.wr       = 1'($urandom_range(1, 0));
    v.size     = 2'($urandom_range(2, 0));
    v.sel      = 4'($urandom_range(15, 0));
    v.addr     = $urandom;
    v.wdata    = $urandom;
    v.a_wait   = int'($urandom_range(3, 0));
    v.d_wait   = int'($urandom_range(3, 0));
    v.rdata    = $urandom;
    v.exp_wr   = v.wr;
    v.exp_strb = v.wr ? v.sel : 4'b0000;
    v.exp_size = v.size;
    v.exp_lat  = 3 + v.a_wait + v.d_wait;
    return v;
  endfunction

  vec_t vecs[6];
  vec_t fetch_v, conf_d, conf_i, lw_mis, pend_i, pend_d;
  logic have_i, have_d;

  initial begin
    // {is_data, wr, size, sel, addr, wdata, a_wait, d_wait, rdata, exp_wr, exp_strb, exp_size, exp_lat}
    fetch_v  = '{1'b0, 1'b0, 2'b00, 4'b0000, 32'hBFC00000, 32'h0, 0, 2, 32'h3C08BFAF, 1'b0, 4'b0000, 2'b10, 5};
    vecs[0]  = '{1'b1, 1'b0, 2'b10, 4'b0000, 32'h80000100, 32'h0, 0, 0, 32'h12345678, 1'b0, 4'b0000, 2'b10, 3};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 4'b1111, 32'h80000104, 32'hCAFEF00D, 1, 0, 32'h00001111, 1'b1, 4'b1111, 2'b10, 4};
    vecs[2]  = '{1'b1, 1'b1, 2'b00, 4'b1000, 32'h80000003, 32'h44444444, 3, 1, 32'h00002222, 1'b1, 4'b1000, 2'b00, 7};
    vecs[3]  = '{1'b1, 1'b1, 2'b01, 4'b1100, 32'h80000006, 32'hBEEFBEEF, 0, 3, 32'h00003333, 1'b1, 4'b1100, 2'b01, 6};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 4'b0000, 32'hBFC00010, 32'h0, 2, 0, 32'h24020001, 1'b0, 4'b0000, 2'b10, 5};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 4'b0010, 32'h80000001, 32'h0, 1, 1, 32'hA5A5A5A5, 1'b0, 4'b0000, 2'b00, 5};
    conf_d   = '{1'b1, 1'b0, 2'b10, 4'b0000, 32'h80000010, 32'h0, 0, 1, 32'h00C0FFEE, 1'b0, 4'b0000, 2'b10, 4};
    conf_i   = '{1'b0, 1'b0, 2'b00, 4'b0000, 32'hBFC00004, 32'h0, 0, 0, 32'h8C040000, 1'b0, 4'b0000, 2'b10, 3};
    lw_mis   = '{1'b1, 1'b0, 2'b10, 4'b0000, 32'h80000002, 32'h0, 0, 0, 32'h55AA55AA, 1'b0, 4'b0000, 2'b10, 3};

    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_sel = 4'b0000;
    data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

    // Reset held two cycles with a fetch already pending.
    @(negedge clk);
    drive_req(fetch_v);
    @(negedge clk);
    @(negedge clk);
    chk("rst bus_req", 32'(bus_req), 32'h0);
    chk("rst bus_wr", 32'(bus_wr), 32'h0);
    chk("rst bus_size", 32'(bus_size), 32'h0);
    chk("rst bus_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    chk("rst inst_ok", 32'(inst_ok), 32'h0);
    chk("rst data_ok", 32'(data_ok), 32'h0);
    chk("rst inst_rdata", inst_rdata, 32'h0);
    chk("rst data_rdata", data_rdata, 32'h0);
    chk("rst addr_err", 32'(addr_err), 32'h0);
    chk("rst state", 32'(o_dbg_state), 32'h0);
    chk("rst stall", 32'(stall), 32'h1);
    rst = 1'b0;
    run_xfer("fetch", fetch_v);
    gap("fetch_gap");

    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i]);
      run_xfer($sformatf("vec%0d", i), vecs[i]);
      gap($sformatf("vec%0d_gap", i));
    end

    // Simultaneous requests: data first, one IDLE cycle, then the held fetch.
    drive_req(conf_i);
    drive_req(conf_d);
    run_xfer("conf_data", conf_d);
    gap("conf_gap");
    run_xfer("conf_inst", conf_i);
    gap("conf_end");

    // Reset while waiting in the data phase; the late data_ok must be dropped.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h80000020;
    @(negedge clk);
    chk("rstd addr_phase", 32'(bus_req), 32'h1);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("rstd data_phase", 32'(bus_req), 32'h0);
    bus_addr_ok = 1'b0;
    rst = 1'b1;
    data_req = 1'b0;
    @(negedge clk);
    m_inst_rd = 32'h0;
    m_data_rd = 32'h0;
    chk("rstd state", 32'(o_dbg_state), 32'h0);
    chk("rstd data_ok", 32'(data_ok), 32'h0);
    chk("rstd data_rdata", data_rdata, m_data_rd);
    rst = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus_data_ok = 1'b0;
      chk("rstd late data_ok", 32'(data_ok), 32'h0);
      chk("rstd late inst_ok", 32'(inst_ok), 32'h0);
      chk("rstd late rdata", data_rdata, m_data_rd);
      chk("rstd late state", 32'(o_dbg_state), 32'h0);
      chk("rstd late bus_req", 32'(bus_req), 32'h0);
    end

    drive_req(lw_mis);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    run_misalign("align");
`else
    run_xfer("align", lw_mis);
`endif
    gap("align_gap");

    have_i = 1'b0;
    have_d = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if (!have_i && $urandom_range(1, 0) == 1) begin
        pend_i = mk_inst(); have_i = 1'b1; drive_req(pend_i);
      end
      if (!have_d && $urandom_range(1, 0) == 1) begin
        pend_d = mk_data(); have_d = 1'b1; drive_req(pend_d);
      end
      if (!have_i && !have_d) begin
        pend_i = mk_inst(); have_i = 1'b1; drive_req(pend_i);
      end
      if (have_d) begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if (misal(pend_d.size, pend_d.addr)) run_misalign("rnd_misal");
        else run_xfer("rnd_data", pend_d);
`else
        run_xfer("rnd_data", pend_d);
`endif
        have_d = 1'b0;
      end else begin
        run_xfer("rnd_inst", pend_i);
        have_i = 1'b0;
      end
      gap("rnd_gap");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the data-memory port of the pipelined MIPS core.
- Data-port requests carry the size and byte-enable (sel) values already produced by the load/store byte-lane selection logic, plus the replicated write data.
- Sequences each transfer through an address phase and a data phase, and returns read data to the requester.
- Drives the pipeline stall while either port is waiting.

Parameters:
- INST_SIZE, 2'b10, bus size code driven for instruction fetches (word).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- inst_req  input  1  fetch request; held until inst_ok
- inst_addr  input  32  fetch address
- inst_rdata  output  32  fetched word, valid when inst_ok
- inst_ok  output  1  one-cycle fetch completion pulse
- data_req  input  1  load/store request; held until data_ok
- data_wr  input  1  1 = store, 0 = load
- data_size  input  2  00 byte, 01 half, 10 word
- data_sel  input  4  store byte enables
- data_addr  input  32  load/store address (aluoutM)
- data_wdata  input  32  lane-replicated store data
- data_rdata  output  32  raw loaded word, valid when data_ok
- data_ok  output  1  one-cycle load/store completion pulse
- addr_err  output  1  misaligned data access flag, valid with data_ok
- stall  output  1  pipeline stall
- bus_req  output  1  address-phase request
- bus_wr  output  1  write flag
- bus_size  output  2  transfer size
- bus_wstrb  output  4  byte strobes; 0000 on reads
- bus_addr  output  32  transfer address
- bus_wdata  output  32  write data
- bus_addr_ok  input  1  slave accepted the address phase
- bus_rdata  input  32  slave read data
- bus_data_ok  input  1  slave completed the data phase

Behaviour:
- Reset (synchronous, active-high, overrides everything): state IDLE; all registered outputs 0; addr_err 0.
- State machine has four states: IDLE, ADDR, DATA, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If data_req=1, grant DATA; else if inst_req=1, grant INST. Data has fixed priority.
  - Latch the granted port's addr, wr, size, wstrb and wdata into the bus registers. Then go to ADDR.
  - INST grant latches wr=0, size=INST_SIZE, wstrb=0000.
  - A data load latches wstrb=0000.
  - bus_data_ok arriving in IDLE is ignored.
- ADDR:
  - bus_req=1. All bus_* fields are held stable until bus_addr_ok=1.
  - bus_addr_ok=1 with bus_data_ok=0: capture nothing, go to DATA; bus_req is 0 from the next cycle.
  - bus_addr_ok=1 with bus_data_ok=1 in the same cycle: capture bus_rdata, go to RESP.
- DATA:
  - bus_req=0. Wait for bus_data_ok=1, then capture bus_rdata into the granted port's rdata register and go to RESP.
- RESP (exactly one cycle):
  - The granted port's ok=1.
  - Requests are ignored in this cycle, so the still-asserted req is not re-issued. Next state is IDLE.
- Latency:
  - Minimum is 3 cycles from req sampled in IDLE to the ok pulse, when the slave returns addr_ok and data_ok together.
  - Each wait cycle of addr_ok or data_ok adds 1 cycle.
  - Back-to-back transfers have a 1-cycle IDLE gap.
- stall = (inst_req & ~inst_ok) | (data_req & ~data_ok). This is combinational.
- rdata registers hold their value until the next capture for that port.
- Reset mid-transaction: return to IDLE immediately; the bus slave shares rst, so no drain is performed.

Optional Feature:
- MEM_ARB_ALIGN_CHECK_EN
- Defined:
  - In IDLE, a data grant with size 10 and addr[1:0]≠00, or size 01 and addr[0]≠0, does not issue bus_req.
  - The FSM goes directly to RESP with data_ok=1, addr_err=1 and data_rdata=0.
  - addr_err is 0 in every other cycle.
- Undefined:
  - addr_err is tied to 0.
  - Misaligned accesses are issued to the bus unchanged.

Test Plan:
- Reset: hold rst for 2 cycles during an active request -> all outputs 0, state IDLE; 1 cycle after release with inst_req=1, bus_req=1.
- Fetch: inst_req, inst_addr=0xBFC00000; slave gives addr_ok immediately and data_ok 2 cycles later with 0x3C08BFAF -> inst_ok single pulse with inst_rdata=0x3C08BFAF, bus_size=10, bus_wstrb=0000, stall=1 until the ok cycle.
- Conflict: inst_req and data_req (load 0x80000010) rise in the same cycle -> first bus_addr=0x80000010, data_ok pulse, then an IDLE gap, then the fetch is issued.
- SB store: data_addr=0x80000003, sel=1000, size=00, wdata=0x44444444, addr_ok delayed 3 cycles -> bus_req, bus_addr, bus_wr=1, bus_wstrb=1000 held stable for all 4 cycles; data_ok pulse after data_ok from the slave.
- Reset mid-DATA: assert rst while waiting for data_ok -> IDLE next cycle; a late bus_data_ok produces no ok pulse.
- Align: LW at 0x80000002 -> with the macro, no bus_req and data_ok=addr_err=1 after 2 cycles; without it, bus_req is issued with bus_addr=0x80000002.
